extend_pipe: RTL and testbench



---
 rtl/extend_pkg.sv | 24 ++
 rtl/field_extend.sv | 58 +++++
 rtl/extend_pipe.sv | 121 ++++++++++++
 tb/tb_extend_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/extend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : extend_pkg
// Purpose  : Shared types and constants for the field-extension pipeline.
//            Holds the extension-mode encoding and the fixed shift amounts
//            used for ARM64 branch offsets and ADD/SUB immediates.
// Revision : 1.0 - initial release
// ============================================================================
package extend_pkg;

    // Extension mode selected per item on in_mode.
    typedef enum logic [1:0] {
        EXT_ZERO       = 2'd0,
        EXT_SIGN       = 2'd1,
        EXT_SIGN_SHL2  = 2'd2,
        EXT_ZERO_SHL12 = 2'd3
    } ext_mode_t;

    // Branch offsets are word-scaled; ADD/SUB immediates may be shifted by 12.
    localparam int unsigned c_SHIFT_BRANCH = 2;
    localparam int unsigned c_SHIFT_ADDSUB = 12;

endpackage : extend_pkg
`default_nettype wire

// File: rtl/field_extend.sv
`default_nettype none
// ============================================================================
// Module   : field_extend
// Purpose  : Combinational field mask / zero- or sign-extension / shift.
//            Keeps the low min(width_i, INPUT_SIZE) bits of data_i, extends
//            them to OUTPUT_SIZE and applies the optional mode shift.
// Revision : 1.0 - initial release
// ============================================================================
module field_extend
    import extend_pkg::*;
#(
    parameter int INPUT_SIZE  = 26,
    parameter int OUTPUT_SIZE = 64,
    parameter int WIDTH_BITS  = $clog2(INPUT_SIZE + 1)
) (
    input  logic [INPUT_SIZE-1:0]  data_i,
    input  logic [WIDTH_BITS-1:0]  width_i,
    input  logic [1:0]             mode_i,
    output logic [OUTPUT_SIZE-1:0] result_o
);

    localparam int PAD = OUTPUT_SIZE - INPUT_SIZE;

    // The <<12 mode must never push field bits off the top of the result.
    if (OUTPUT_SIZE < INPUT_SIZE + 12) begin : g_size_check
        $error("field_extend: OUTPUT_SIZE must be >= INPUT_SIZE + 12");
    end

    int                     width_eff;
    logic [INPUT_SIZE-1:0]  field_mask;
    logic [INPUT_SIZE-1:0]  msb_sel;
    logic [INPUT_SIZE-1:0]  field;
    logic                   sign_bit;
    logic [OUTPUT_SIZE-1:0] zext;
    logic [OUTPUT_SIZE-1:0] sext;

    // Mask the selected field, find its top bit, then extend and shift by mode.
    always_comb begin
        width_eff  = (int'(width_i) > INPUT_SIZE) ? INPUT_SIZE : int'(width_i);
        // Width 0 shifts the all-ones mask fully out, yielding an empty field.
        field_mask = {INPUT_SIZE{1'b1}} >> (INPUT_SIZE - width_eff);
        // Isolate bit w-1 without a variable index: it is the mask's top bit.
        msb_sel    = field_mask & ~(field_mask >> 1);
        field      = data_i & field_mask;
        sign_bit   = |(field & msb_sel);
        zext       = {{PAD{1'b0}}, field};
        sext       = sign_bit ? (zext | ~{{PAD{1'b0}}, field_mask}) : zext;
        case (ext_mode_t'(mode_i))
            EXT_ZERO:       result_o = zext;
            EXT_SIGN:       result_o = sext;
            EXT_SIGN_SHL2:  result_o = sext << c_SHIFT_BRANCH;
            EXT_ZERO_SHL12: result_o = zext << c_SHIFT_ADDSUB;
            default:        result_o = zext;
        endcase
    end

endmodule : field_extend
`default_nettype wire

// File: rtl/extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : extend_pipe
// Purpose  : Field-extension unit followed by a DEPTH-stage elastic
//            valid/ready pipeline. Extension happens ahead of stage 0;
//            later stages only carry data. Full throughput, FIFO order,
//            stalls propagate combinationally back from out_ready.
// Revision : 1.0 - initial release
// ============================================================================
module extend_pipe
    import extend_pkg::*;
#(
    parameter  int INPUT_SIZE  = 26,
    parameter  int OUTPUT_SIZE = 64,
    parameter  int DEPTH       = 2,
    localparam int WIDTH_BITS  = $clog2(INPUT_SIZE + 1),
    localparam int OCC_BITS    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_SIZE-1:0]  in_data,
    input  logic [WIDTH_BITS-1:0]  in_width,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUTPUT_SIZE-1:0] out_data,
    output logic [OCC_BITS-1:0]    occupancy
);

    if (DEPTH < 1) begin : g_depth_check
        $error("extend_pipe: DEPTH must be >= 1");
    end
    if (INPUT_SIZE < 1) begin : g_input_check
        $error("extend_pipe: INPUT_SIZE must be >= 1");
    end

    logic [OUTPUT_SIZE-1:0] ext_result;
    logic [DEPTH-1:0]       stage_valid;
    logic [DEPTH-1:0]       stage_adv;
    logic [OUTPUT_SIZE-1:0] stage_data [DEPTH];

    field_extend #(
        .INPUT_SIZE  (INPUT_SIZE),
        .OUTPUT_SIZE (OUTPUT_SIZE),
        .WIDTH_BITS  (WIDTH_BITS)
    ) u_field_extend (
        .data_i   (in_data),
        .width_i  (in_width),
        .mode_i   (in_mode),
        .result_o (ext_result)
    );

    // Ready chain from the output back: a stage loads if empty or its successor loads.
    always_comb begin
        stage_adv            = '0;
        stage_adv[DEPTH-1]   = ~stage_valid[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            stage_adv[k] = ~stage_valid[k] | stage_adv[k+1];
        end
    end

    assign in_ready = stage_adv[0] & ~reset;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic                   src_valid;
        logic [OUTPUT_SIZE-1:0] src_data;
        logic                   valid_q;
        logic                   valid_d;
        logic [OUTPUT_SIZE-1:0] data_q;
        logic [OUTPUT_SIZE-1:0] data_d;

        if (k == 0) begin : g_src_input
            assign src_valid = in_valid & in_ready;
            assign src_data  = ext_result;
        end else begin : g_src_stage
            assign src_valid = stage_valid[k-1];
            assign src_data  = stage_data[k-1];
        end

        // Take the upstream item (or bubble) when advancing; data only changes on a real item.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (stage_adv[k]) begin
                valid_d = src_valid;
                if (src_valid) begin
                    data_d = src_data;
                end
            end
        end

        // Stage register; reset drops any in-flight item.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign stage_valid[k] = valid_q;
        assign stage_data[k]  = data_q;
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

    // Occupancy is the population count of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_BITS'(stage_valid[k]);
        end
    end

endmodule : extend_pipe
`default_nettype wire

// File: tb/tb_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_extend_pipe
// Purpose  : Scoreboard bench for extend_pipe. Three instances (DEPTH 2, 1
//            and 4) share the stimulus; expected results are queued on
//            acceptance and popped by a monitor when each DUT emits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_extend_pipe;
    import extend_pkg::*;

    localparam int IW = 26;
    localparam int OW = 64;

    typedef struct {
        logic [OW-1:0] data;
        int            acc_cyc;
        bit            chk;
    } exp_t;

    typedef struct {
        logic [IW-1:0] d;
        logic [4:0]    w;
        logic [1:0]    m;
        logic [OW-1:0] e;
    } vec_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic          aux_en    = 1'b0;
    logic          aux_ready = 1'b1;
    logic [IW-1:0] in_data   = '0;
    logic [4:0]    in_width  = '0;
    logic [1:0]    in_mode   = '0;
    logic          in_valid_aux;

    logic          ir1, ir2, ir4;
    logic          ov1, ov2, ov4;
    logic [OW-1:0] od1, od2, od4;
    logic          occ1;
    logic [1:0]    occ2;
    logic [2:0]    occ4;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    logic [OW-1:0] cur_exp = '0;
    bit            cur_chk = 1'b0;
    exp_t          q1[$];
    exp_t          q2[$];
    exp_t          q4[$];
    vec_t          vecs[12];

    assign in_valid_aux = in_valid & aux_en;

    always #5 clk = ~clk;

    extend_pipe #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW), .DEPTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
        .in_data(in_data), .in_width(in_width), .in_mode(in_mode),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2)
    );

    extend_pipe #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_aux), .in_ready(ir1),
        .in_data(in_data), .in_width(in_width), .in_mode(in_mode),
        .out_valid(ov1), .out_ready(aux_ready), .out_data(od1), .occupancy(occ1)
    );

    extend_pipe #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid_aux), .in_ready(ir4),
        .in_data(in_data), .in_width(in_width), .in_mode(in_mode),
        .out_valid(ov4), .out_ready(aux_ready), .out_data(od4), .occupancy(occ4)
    );

    task automatic check(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic chk_pop(input string tag, input bit have, input exp_t e,
                           input logic [OW-1:0] act, input int dep);
        n_chk++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s unexpected output: got %h, required none", tag, act);
        end else if (act !== e.data) begin
            n_fail++;
            $display("FAIL %s data: got %h, required %h", tag, act, e.data);
        end
        if (have && e.chk) begin
            n_chk++;
            if (cyc - e.acc_cyc != dep) begin
                n_fail++;
                $display("FAIL %s latency: got %0d, required %0d", tag, cyc - e.acc_cyc, dep);
            end
        end
    endtask

    // Present one item and hold it until the DEPTH-2 instance accepts it.
    task automatic send(input logic [IW-1:0] d, input logic [4:0] w, input logic [1:0] m,
                        input logic [OW-1:0] e, input bit chk);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_width = w;
        in_mode  = m;
        cur_exp  = e;
        cur_chk  = chk;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = ir2;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_chk++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 for 50 cycles, required acceptance");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (q1.size() == 0 && q2.size() == 0 && q4.size() == 0) break;
        end
    endtask

    initial begin
        vecs[0]  = '{26'h3FFFFFF, 5'd12, EXT_ZERO,       64'h0000_0000_0000_0FFF};
        vecs[1]  = '{26'h2AAA1F0, 5'd9,  EXT_SIGN,       64'hFFFF_FFFF_FFFF_FFF0};
        vecs[2]  = '{26'h0040000, 5'd19, EXT_SIGN_SHL2,  64'hFFFF_FFFF_FFF0_0000};
        vecs[3]  = '{26'h0000ABC, 5'd12, EXT_ZERO_SHL12, 64'h0000_0000_00AB_C000};
        vecs[4]  = '{26'h3FFFFFF, 5'd0,  EXT_SIGN,       64'h0};
        vecs[5]  = '{26'h3FFFFFF, 5'd0,  EXT_SIGN_SHL2,  64'h0};
        vecs[6]  = '{26'h2000000, 5'd30, EXT_SIGN,       64'hFFFF_FFFF_FE00_0000};
        vecs[7]  = '{26'h0000001, 5'd1,  EXT_SIGN,       64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8]  = '{26'h3FFFFFF, 5'd26, EXT_ZERO_SHL12, 64'h0000_003F_FFFF_F000};
        vecs[9]  = '{26'h3FFFFFF, 5'd31, EXT_ZERO,       64'h0000_0000_03FF_FFFF};
        vecs[10] = '{26'h0000002, 5'd1,  EXT_SIGN,       64'h0};
        vecs[11] = '{26'h3FFFFFF, 5'd0,  EXT_ZERO_SHL12, 64'h0};

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            begin : mon
                bit   have;
                exp_t e;
                exp_t ent;
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        q1.delete();
                        q2.delete();
                        q4.delete();
                    end else begin
                        if (ov2 && out_ready) begin
                            have = (q2.size() != 0);
                            if (have) e = q2.pop_front();
                            chk_pop("d2_out", have, e, od2, 2);
                        end
                        if (ov1 && aux_ready) begin
                            have = (q1.size() != 0);
                            if (have) e = q1.pop_front();
                            chk_pop("d1_out", have, e, od1, 1);
                        end
                        if (ov4 && aux_ready) begin
                            have = (q4.size() != 0);
                            if (have) e = q4.pop_front();
                            chk_pop("d4_out", have, e, od4, 4);
                        end
                        ent.data    = cur_exp;
                        ent.acc_cyc = cyc;
                        ent.chk     = cur_chk;
                        if (in_valid && ir2)     q2.push_back(ent);
                        if (in_valid_aux && ir1) q1.push_back(ent);
                        if (in_valid_aux && ir4) q4.push_back(ent);
                    end
                end
            end
            begin
                #100000;
                $display("FAIL watchdog: got no end of test, required finish within 100000 time units");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset held with in_valid asserted: nothing accepted, outputs cleared.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 26'h3FFFFFF;
        in_width = 5'd12;
        in_mode  = EXT_ZERO;
        @(posedge clk);
        #1;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready",  {63'd0, ir2},  64'd0);
            check("rst_out_valid", {63'd0, ov2},  64'd0);
            check("rst_out_data",  od2,           64'd0);
            check("rst_occ",       {62'd0, occ2}, 64'd0);
            check("rst_occ_d1",    {63'd0, occ1}, 64'd0);
            check("rst_occ_d4",    {61'd0, occ4}, 64'd0);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, ir2}, 64'd1);
        @(posedge clk);
        #1;

        // Extension vectors streamed back-to-back into all three depths.
        aux_en    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].d, vecs[i].w, vecs[i].m, vecs[i].e, 1'b1);
        end
        drain();
        aux_en = 1'b0;

        // Backpressure: A..D with the output stalled, then released.
        out_ready = 1'b0;
        fork
            begin
                send(26'h0012345, 5'd8,  EXT_ZERO,      64'h0000_0000_0000_0045, 1'b0);
                send(26'h0000080, 5'd8,  EXT_SIGN,      64'hFFFF_FFFF_FFFF_FF80, 1'b0);
                send(26'h000BEEF, 5'd16, EXT_ZERO,      64'h0000_0000_0000_BEEF, 1'b0);
                send(26'h0000007, 5'd4,  EXT_SIGN_SHL2, 64'h0000_0000_0000_001C, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                @(negedge clk);
                check("bp_occ_full",  {62'd0, occ2}, 64'd2);
                check("bp_in_ready",  {63'd0, ir2},  64'd0);
                check("bp_out_valid", {63'd0, ov2},  64'd1);
                check("bp_hold_a0",   od2,           64'h45);
                @(posedge clk);
                #1;
                @(negedge clk);
                check("bp_hold_a1",   od2,           64'h45);
                check("bp_hold_v1",   {63'd0, ov2},  64'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_swap_ready", {63'd0, ir2},  64'd1);
                check("bp_swap_occ0",  {62'd0, occ2}, 64'd2);
                @(posedge clk);
                #1;
                @(negedge clk);
                check("bp_swap_occ1",  {62'd0, occ2}, 64'd2);
            end
        join
        drain();

        // Reset with two items in flight: both discarded.
        out_ready = 1'b0;
        send(26'h0000005, 5'd4, EXT_ZERO, 64'h5, 1'b0);
        send(26'h0000006, 5'd4, EXT_ZERO, 64'h6, 1'b0);
        @(negedge clk);
        check("mid_occ_before", {62'd0, occ2}, 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_occ_after",   {62'd0, occ2}, 64'd0);
        check("mid_valid_after", {63'd0, ov2},  64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Fresh item after reset: latency must equal DEPTH on each instance.
        aux_en = 1'b1;
        send(26'h0000003, 5'd4, EXT_ZERO_SHL12, 64'h0000_0000_0000_3000, 1'b1);
        drain();
        aux_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("end_q1_empty", 64'(q1.size()), 64'd0);
        check("end_q2_empty", 64'(q2.size()), 64'd0);
        check("end_q4_empty", 64'(q4.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_extend_pipe
`default_nettype wire
